// File: rtl/credit_return_gen.sv
// Receiver-side credit return generator: accumulates freed RX slots and returns them as batched credits.
// Optional idle-timeout return enabled by defining CREDIT_RETURN_TIMEOUT_EN.
module credit_return_gen #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned THRESHOLD    = 4,
  parameter int unsigned INIT_CREDITS = 8,
  parameter int unsigned TIMEOUT      = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             free_valid_i,
  input  logic [WIDTH-1:0] free_cnt_i,
  output logic             credit_valid_o,
  input  logic             credit_ready_i,
  output logic [WIDTH-1:0] credit_o,
  output logic             pending_o,
  output logic             overflow_o
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned SW = WIDTH + 2;
  localparam logic [AW-1:0] MAX_RET = {1'b0, {WIDTH{1'b1}}};
  localparam logic [AW-1:0] ACC_MAX = {AW{1'b1}};
  localparam logic [AW-1:0] THR     = AW'(THRESHOLD);
  localparam logic [AW-1:0] INIT    = AW'(INIT_CREDITS);

  typedef enum logic {S_IDLE, S_SEND} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] credit_q, credit_d;
  logic             valid_q;
  logic             ovf_q, ovf_d;
  logic             pending_q;
  logic [WIDTH-1:0] amt;
  logic [SW-1:0]    sum;
  logic             launch;
  logic             timeout_hit;

`ifdef CREDIT_RETURN_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] timer_q, timer_d;

  // Ages a sub-threshold balance sitting in IDLE; restarts whenever it is returned or drained.
  always_comb begin
    timer_d     = timer_q;
    timeout_hit = (timer_q == TW'(TIMEOUT - 1));
    if (clear_i || launch || (acc_q == '0)) begin
      timer_d = '0;
    end else if ((state_q == S_IDLE) && (acc_q < THR)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT == 0);
  assign timeout_hit        = 1'b0;
`endif

  // Next-state, accumulator and return-amount logic.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;

    amt    = (acc_q > MAX_RET) ? {WIDTH{1'b1}} : acc_q[WIDTH-1:0];
    launch = (state_q == S_IDLE) && !clear_i &&
             ((acc_q >= THR) || ((acc_q != '0) && timeout_hit));

    // Frees arriving in the launch cycle are still added, so nothing is lost.
    sum = SW'(acc_q)
        + (free_valid_i ? SW'(free_cnt_i) : SW'(0))
        - (launch ? SW'(amt) : SW'(0));

    if (clear_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (sum > SW'(ACC_MAX)) begin
      acc_d = ACC_MAX;
      ovf_d = 1'b1;
    end else begin
      acc_d = sum[AW-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d  = S_SEND;
          credit_d = amt;
        end
      end
      S_SEND: begin
        if (credit_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so they track state/acc exactly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      acc_q     <= INIT;
      credit_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      pending_q <= (INIT_CREDITS != 0);
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      credit_q  <= credit_d;
      valid_q   <= (state_d == S_SEND);
      ovf_q     <= ovf_d;
      pending_q <= (acc_d != '0) || (state_d == S_SEND);
    end
  end

  assign credit_valid_o = valid_q;
  assign credit_o       = credit_q;
  assign pending_o      = pending_q;
  assign overflow_o     = ovf_q;

endmodule

// File: tb/tb_credit_return_gen.sv
// Self-checking bench for credit_return_gen: directed table, corner sequences and random traffic vs. a reference model.
module tb_credit_return_gen;

  localparam int WIDTH        = 8;
  localparam int THRESHOLD    = 4;
  localparam int INIT_CREDITS = 8;
  localparam int TIMEOUT      = 16;
  localparam int MAX_RET      = (1 << WIDTH) - 1;
  localparam int ACC_MAX      = (1 << (WIDTH + 1)) - 1;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             clear_i = 1'b0;
  logic             free_valid_i = 1'b0;
  logic [WIDTH-1:0] free_cnt_i = '0;
  logic             credit_valid_o;
  logic             credit_ready_i = 1'b0;
  logic [WIDTH-1:0] credit_o;
  logic             pending_o;
  logic             overflow_o;

  credit_return_gen #(
    .WIDTH(WIDTH), .THRESHOLD(THRESHOLD), .INIT_CREDITS(INIT_CREDITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .free_valid_i(free_valid_i), .free_cnt_i(free_cnt_i),
    .credit_valid_o(credit_valid_o), .credit_ready_i(credit_ready_i),
    .credit_o(credit_o), .pending_o(pending_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: credit balance, whether a message is on the wire, its payload, sticky overflow, idle age.
  int m_bal, m_credit, m_age;
  bit m_busy, m_ovf;

  task automatic model_reset();
    m_bal = INIT_CREDITS; m_credit = 0; m_age = 0; m_busy = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit clr, input bit fv, input int fc, input bit rdy);
    bit expired, go;
    int chunk, total;
`ifdef CREDIT_RETURN_TIMEOUT_EN
    expired = (m_age == TIMEOUT - 1);
`else
    expired = 0;
`endif
    go    = !m_busy && !clr && (m_bal >= THRESHOLD || (m_bal > 0 && expired));
    chunk = (m_bal < MAX_RET) ? m_bal : MAX_RET;
    if (clr || go || m_bal == 0) m_age = 0;
    else if (!m_busy && m_bal < THRESHOLD) m_age++;
    total = m_bal + (fv ? fc : 0) - (go ? chunk : 0);
    if (clr) begin
      m_bal = 0; m_ovf = 0;
    end else if (total > ACC_MAX) begin
      m_bal = ACC_MAX; m_ovf = 1;
    end else begin
      m_bal = total;
    end
    if (m_busy && rdy) m_busy = 0;
    if (go) begin
      m_busy = 1; m_credit = chunk;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("valid", int'(credit_valid_o), int'(m_busy));
    chk("credit", int'(credit_o), m_credit);
    chk("pending", int'(pending_o), int'(m_bal != 0 || m_busy));
    chk("overflow", int'(overflow_o), int'(m_ovf));
  endtask

  // Applies one cycle of inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input bit clr, input bit fv, input int fc, input bit rdy);
    clear_i = clr; free_valid_i = fv; free_cnt_i = WIDTH'(fc); credit_ready_i = rdy;
    model_step(clr, fv, fc, rdy);
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    bit clr; bit fv; int fc; bit rdy;
    bit ev; int ec; bit ep; bit eo;
  } vec_t;

  vec_t tbl[10];
  int   rets[$];
  int   exp_rets[$];
  int   seen_at;
  int   seen_credit;

  initial begin
    // Post-reset advertisement, threshold trigger and the start of a back-pressured return.
    tbl[0] = '{0, 0, 0, 1, 1, 8, 1, 0};
    tbl[1] = '{0, 0, 0, 1, 0, 8, 0, 0};
    tbl[2] = '{0, 1, 1, 1, 0, 8, 1, 0};
    tbl[3] = '{0, 1, 1, 1, 0, 8, 1, 0};
    tbl[4] = '{0, 1, 1, 1, 0, 8, 1, 0};
    tbl[5] = '{0, 1, 1, 1, 0, 8, 1, 0};
    tbl[6] = '{0, 0, 0, 1, 1, 4, 1, 0};
    tbl[7] = '{0, 0, 0, 1, 0, 4, 0, 0};
    tbl[8] = '{0, 1, 4, 0, 0, 4, 1, 0};
    tbl[9] = '{0, 1, 2, 0, 1, 4, 1, 0};

    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", int'(credit_valid_o), 0);
    chk("rst_credit", int'(credit_o), 0);
    chk("rst_overflow", int'(overflow_o), 0);
    chk("rst_pending", int'(pending_o), 1);
    rst_ni = 1'b1;

    for (int i = 0; i < 10; i++) begin
      cyc(tbl[i].clr, tbl[i].fv, tbl[i].fc, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), int'(credit_valid_o), int'(tbl[i].ev));
      chk($sformatf("tbl%0d_credit", i), int'(credit_o), tbl[i].ec);
      chk($sformatf("tbl%0d_pending", i), int'(pending_o), int'(tbl[i].ep));
      chk($sformatf("tbl%0d_overflow", i), int'(overflow_o), int'(tbl[i].eo));
    end

    // Back-pressure: payload of 4 holds while 2 credits arrive every cycle.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1, 2, 0);
      chk("bp_hold_valid", int'(credit_valid_o), 1);
      chk("bp_hold_credit", int'(credit_o), 4);
    end
    cyc(0, 0, 0, 1);
    chk_model();
    cyc(0, 0, 0, 1);
    chk("bp_next_credit", int'(credit_o), 22);
    chk_model();
    cyc(0, 0, 0, 1);
    chk("bp_drained_pending", int'(pending_o), 0);

    // Single sub-threshold free, then idle.
    cyc(0, 1, 2, 1);
    seen_at = -1; seen_credit = -1;
    for (int i = 1; i <= 24; i++) begin
      cyc(0, 0, 0, 1);
      chk_model();
      if (credit_valid_o && seen_at < 0) begin
        seen_at = i; seen_credit = int'(credit_o);
      end
    end
`ifdef CREDIT_RETURN_TIMEOUT_EN
    chk("timeout_cycle", seen_at, 16);
    chk("timeout_credit", seen_credit, 2);
`else
    chk("no_timeout_return", seen_at, -1);
    chk("no_timeout_pending", int'(pending_o), 1);
`endif
    cyc(1, 0, 0, 1);
    chk_model();

    // Saturation under back-pressure, then chunked drain.
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 255, 0);
      chk_model();
    end
    chk("sat_overflow", int'(overflow_o), 1);
    rets.delete();
    for (int i = 0; i < 40; i++) begin
      if (credit_valid_o) rets.push_back(int'(credit_o));
      cyc(0, 0, 0, 1);
      chk_model();
    end
    exp_rets = '{255, 255, 255};
`ifdef CREDIT_RETURN_TIMEOUT_EN
    exp_rets.push_back(1);
`endif
    chk("chunk_count", rets.size(), exp_rets.size());
    for (int i = 0; i < exp_rets.size() && i < rets.size(); i++)
      chk($sformatf("chunk%0d", i), rets[i], exp_rets[i]);

    // Clear while a return of 6 is on the wire.
    cyc(1, 0, 0, 0);
    cyc(0, 1, 6, 0);
    cyc(0, 0, 0, 0);
    chk("clr_send_credit", int'(credit_o), 6);
    cyc(1, 1, 3, 0);
    chk("clr_keep_valid", int'(credit_valid_o), 1);
    chk("clr_keep_credit", int'(credit_o), 6);
    chk("clr_overflow", int'(overflow_o), 0);
    cyc(0, 0, 0, 1);
    chk("clr_done_valid", int'(credit_valid_o), 0);
    chk("clr_done_pending", int'(pending_o), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 1);
      chk_model();
    end

    // Asynchronous reset in the middle of a return.
    cyc(0, 1, 9, 0);
    cyc(0, 0, 0, 0);
    chk("arst_pre_valid", int'(credit_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", int'(credit_valid_o), 0);
    chk("arst_credit", int'(credit_o), 0);
    chk("arst_pending", int'(pending_o), 1);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    cyc(0, 0, 0, 1);
    chk("readvertise_credit", int'(credit_o), INIT_CREDITS);
    chk_model();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int fc;
      fc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 3));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) != 0, fc, $urandom_range(0, 1) == 1);
      chk_model();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/credit_return_gen.md
Name: credit_return_gen

Overview:
- Receiver-side credit return generator for credit-based flow control; it is the far end of the sender's up/down credit counter.
- Accumulates buffer slots freed by the local consumer and returns them to the sender as batched credit messages over a valid/ready handshake.
- Sends a return when the accumulated count reaches a threshold, on the initial post-reset advertisement, or on an idle timeout.
- Sits between the RX buffer release logic and the credit-return channel to the link partner.

Parameters:
- WIDTH, 8, width of credit_o and free_cnt_i; one return carries at most 2^WIDTH-1 credits.
- THRESHOLD, 4, accumulated credits that trigger a return; range 1..2^WIDTH-1.
- INIT_CREDITS, 8, accumulator reset value; advertised by the first return after reset.
- TIMEOUT, 16, idle cycles before a sub-threshold return; must be ≥1; used only with CREDIT_RETURN_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- clear_i  in  1  synchronous clear of accumulator, timer and overflow
- free_valid_i  in  1  free_cnt_i is valid this cycle
- free_cnt_i  in  WIDTH  number of slots freed this cycle
- credit_valid_o  out  1  credit return valid
- credit_ready_i  in  1  partner accepts the return
- credit_o  out  WIDTH  credits carried by the current return
- pending_o  out  1  accumulator non-zero or a return is in flight
- overflow_o  out  1  sticky accumulator-saturation flag

Behaviour:
- Reset values (rst_ni low):
  - state IDLE, acc_q = INIT_CREDITS, timer = 0.
  - credit_valid_o = 0, credit_o = 0, overflow_o = 0.
  - pending_o = (INIT_CREDITS != 0).
- Accumulator acc_q is WIDTH+1 bits.
  - Next value: acc_q + (free_valid_i ? free_cnt_i : 0) - (launch ? amt : 0).
  - If the result exceeds 2^(WIDTH+1)-1, it saturates to that value and overflow_o is set to 1.
  - overflow_o stays set until clear_i or reset.
- amt = min(acc_q, 2^WIDTH-1).
- State IDLE:
  - launch = (acc_q ≥ THRESHOLD) or (acc_q != 0 and timeout_hit).
  - On launch, credit_o <= amt and the next state is SEND.
  - The free input in the launch cycle is added to the accumulator; it is never lost.
- State SEND:
  - credit_valid_o = 1.
  - credit_o is held stable until credit_valid_o && credit_ready_i.
  - On that handshake the next state is IDLE.
  - There is no direct SEND-to-SEND transition, so there is a minimum 1-cycle gap between returns.
  - Returns larger than 2^WIDTH-1 are split into successive chunks.
- Latency: a free pulse in cycle n that brings acc_q to ≥ THRESHOLD gives credit_valid_o = 1 in cycle n+2.
- Initial advertisement: because acc_q resets to INIT_CREDITS, the first return issues 1 cycle after reset release when INIT_CREDITS ≥ THRESHOLD. Otherwise it follows the threshold/timeout rules.
- clear_i:
  - acc_q, timer and overflow_o go to 0 next cycle; clear_i has priority over free input.
  - A return already in SEND is not retracted and completes normally.
  - No new launch occurs in a cycle where clear_i = 1.
- pending_o = (acc_q != 0) || (state == SEND).
- Asynchronous reset mid-SEND drops credit_valid_o immediately. The partner resyncs from the new initial advertisement.

Optional Feature:
- Macro: CREDIT_RETURN_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT+1) bits increments each IDLE cycle while 0 < acc_q < THRESHOLD.
  - The counter resets to 0 on launch, on acc_q == 0, or on clear_i.
  - timeout_hit = (timer == TIMEOUT-1).
  - A sub-threshold balance is therefore returned TIMEOUT cycles after it went idle.
- Not defined: no timer logic; timeout_hit = 0. Sub-threshold credits stay pending until further frees reach THRESHOLD.

Test Plan:
- Initial advertisement (WIDTH=8, THRESHOLD=4, INIT_CREDITS=8):
  - Stimulus: release reset, credit_ready_i = 1.
  - Required: credit_valid_o = 1 with credit_o = 8 in cycle 1; handshake completes; pending_o = 0 afterwards.
- Threshold trigger:
  - Stimulus: free_cnt_i = 1 in 4 separate cycles; the 4th pulse is in cycle n.
  - Required: credit_valid_o rises in cycle n+2 with credit_o = 4; acc_q = 0 after the handshake.
- Backpressure:
  - Stimulus: credit_ready_i = 0 for 10 cycles during a return of 4, while free_cnt_i = 2 every cycle.
  - Required: credit_o holds 4 throughout; the next return carries 20 (or the accumulated total at launch).
- Timeout (TIMEOUT=16), single free of 2 and no further frees:
  - Macro defined: credit_o = 2 is returned after 16 idle cycles.
  - Macro undefined: no return occurs and pending_o stays 1.
- Chunking and saturation (credit_ready_i = 0, free_cnt_i = 255 each cycle):
  - Required: acc_q saturates at 511 and overflow_o = 1.
  - Then assert credit_ready_i: returns are 255, 255, then 1 (after the already-latched return), and the minimum 1-cycle gap between returns is preserved.
- Clear during SEND:
  - Stimulus: pulse clear_i while a return of 6 is pending.
  - Required: credit_o = 6 still completes; acc_q = 0 and overflow_o = 0 afterwards; no further return is issued.
